// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event generator.
// Holds the FSM state enum, default timing constants and the timer sizing helper.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_e;

    localparam int DEFAULT_HOLD_CYCLES   = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES = 10_000_000;
    localparam int PRESS_COUNT_W         = 8;

    // One spare bit above the largest terminal value so the counter never wraps.
    function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
        return $clog2((hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles) + 1;
    endfunction

endpackage

// File: rtl/button_event_gen_cycle_timer.sv
// Clearable up-counter with a terminal-count compare against a selectable limit.
// Clear has priority over enable; the owner clears it on every terminal count.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/auto-repeat strobes,
// a held level and a wrapping press counter. All outputs come straight from flops.
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_debounc,
    output logic                     press_pulse,
    output logic                     release_pulse,
    output logic                     repeat_pulse,
    output logic                     held,
    output logic [PRESS_COUNT_W-1:0] press_count,
    output state_e                   state_dbg
);

    localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
    // Timer reads 0 right after the arming edge, so the event edge sees limit = cycles-1.
    localparam logic [TW-1:0] HOLD_LIMIT   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LIMIT = TW'(REPEAT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic                     btn_q;
    logic                     press_pulse_q, press_pulse_d;
    logic                     release_pulse_q, release_pulse_d;
    logic                     repeat_pulse_q, repeat_pulse_d;
    logic                     held_q, held_d;
    logic [PRESS_COUNT_W-1:0] press_count_q, press_count_d;

    logic          press_evt;
    logic          rel_evt;
    logic          timer_clr;
    logic          timer_tc;
    logic [TW-1:0] timer_limit;

    assign press_evt   = btn_debounc & ~btn_q;
    assign rel_evt     = ~btn_debounc & btn_q;
    assign timer_limit = (state_q == REPEAT) ? REPEAT_LIMIT : HOLD_LIMIT;

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (reset),
        .clr   (timer_clr),
        .en    (state_q != IDLE),
        .limit (timer_limit),
        .tc    (timer_tc)
    );

    always_comb begin
        state_d         = state_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        repeat_pulse_d  = 1'b0;
        held_d          = held_q;
        press_count_d   = press_count_q;
        timer_clr       = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (press_evt) begin
                    state_d       = PRESSED;
                    press_pulse_d = 1'b1;
                    held_d        = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                end
            end
            PRESSED, REPEAT: begin
                // Release is checked first so it swallows a repeat due on the same edge.
                if (rel_evt) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                    held_d          = 1'b0;
                    timer_clr       = 1'b1;
                end else if (timer_tc) begin
                    state_d        = REPEAT;
                    repeat_pulse_d = 1'b1;
                    timer_clr      = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                held_d    = 1'b0;
                timer_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            btn_q           <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_pulse_q  <= 1'b0;
            held_q          <= 1'b0;
            press_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            btn_q           <= btn_debounc;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            repeat_pulse_q  <= repeat_pulse_d;
            held_q          <= held_d;
            press_count_q   <= press_count_d;
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;
    assign held          = held_q;
    assign press_count   = press_count_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: two instances (repeat period 2 and 1) share one button,
// an edge-arithmetic reference model fills a queue, and a monitor checks every cycle.
module tb_button_event_gen;
    import button_event_pkg::*;

    localparam int HOLD = 4;
    localparam int H_P[2] = '{4, 4};
    localparam int R_P[2] = '{2, 1};

    logic clk;
    logic reset_n;
    logic btn;

    logic       press_a, rel_a, rep_a, held_a;
    logic [7:0] cnt_a;
    state_e     st_a;
    logic       press_b, rel_b, rep_b, held_b;
    logic [7:0] cnt_b;
    state_e     st_b;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];

    int m_prev[2];
    int m_active[2];
    int m_p[2];
    int m_n[2];
    int m_count[2];
    int model_press = 0;
    int model_rel   = 0;
    int mon_press   = 0;
    int mon_rel     = 0;

    button_event_gen #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(2)) dut_a (
        .clk           (clk),
        .reset         (reset_n),
        .btn_debounc   (btn),
        .press_pulse   (press_a),
        .release_pulse (rel_a),
        .repeat_pulse  (rep_a),
        .held          (held_a),
        .press_count   (cnt_a),
        .state_dbg     (st_a)
    );

    button_event_gen #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(1)) dut_b (
        .clk           (clk),
        .reset         (reset_n),
        .btn_debounc   (btn),
        .press_pulse   (press_b),
        .release_pulse (rel_b),
        .repeat_pulse  (rep_b),
        .held          (held_b),
        .press_count   (cnt_b),
        .state_dbg     (st_b)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i]   = 0;
            m_active[i] = 0;
            m_p[i]      = 0;
            m_n[i]      = 0;
            m_count[i]  = 0;
        end
    endtask

    // Apply one button level for the next edge, push the model's view of that edge.
    task automatic drive_cycle(input logic b);
        logic [23:0] e;
        logic [11:0] f;
        int          d;
        logic        pr, rl, rp;
        e   = '0;
        btn = b;
        for (int i = 0; i < 2; i++) begin
            m_n[i]++;
            pr = (b == 1'b1) && (m_prev[i] == 0);
            rl = (b == 1'b0) && (m_prev[i] == 1) && (m_active[i] == 1);
            rp = 1'b0;
            if (pr) begin
                m_active[i] = 1;
                m_p[i]      = m_n[i];
                m_count[i]  = (m_count[i] + 1) % 256;
            end else if (rl) begin
                m_active[i] = 0;
            end else if (m_active[i] == 1) begin
                d = m_n[i] - m_p[i];
                if (d >= H_P[i] && ((d - H_P[i]) % R_P[i]) == 0) rp = 1'b1;
            end
            m_prev[i] = b ? 1 : 0;
            f = {pr, rl, rp, (m_active[i] == 1), 8'(m_count[i])};
            if (i == 0) begin
                e[23:12] = f;
                if (pr) model_press++;
                if (rl) model_rel++;
            end else begin
                e[11:0] = f;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Pulse reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input logic b_during);
        #1;
        reset_n = 1'b0;
        btn     = b_during;
        #1;
        total++;
        if ({press_a, rel_a, rep_a, held_a, cnt_a} !== 12'h000) begin
            bad++;
            $display("FAIL reset_clear_a: got=%03h want=000", {press_a, rel_a, rep_a, held_a, cnt_a});
        end
        total++;
        if ({press_b, rel_b, rep_b, held_b, cnt_b} !== 12'h000) begin
            bad++;
            $display("FAIL reset_clear_b: got=%03h want=000", {press_b, rel_b, rep_b, held_b, cnt_b});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_level(input logic b, input int n);
        for (int k = 0; k < n; k++) drive_cycle(b);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [23:0] e;
        logic [11:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {press_a, rel_a, rep_a, held_a, cnt_a};
                total++;
                if (act !== e[23:12]) begin
                    bad++;
                    $display("FAIL outputs_a t=%0t {press,rel,rep,held,count}: got=%03h want=%03h", $time, act, e[23:12]);
                end
                act = {press_b, rel_b, rep_b, held_b, cnt_b};
                total++;
                if (act !== e[11:0]) begin
                    bad++;
                    $display("FAIL outputs_b t=%0t {press,rel,rep,held,count}: got=%03h want=%03h", $time, act, e[11:0]);
                end
                if (press_a) mon_press++;
                if (rel_a) mon_rel++;
            end
        end
    end

    // Stimulus
    initial begin
        int snap_p;
        int snap_r;
        logic lvl;
        reset_n = 1'b0;
        btn     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({press_a, rel_a, rep_a, held_a, cnt_a, press_b, rel_b, rep_b, held_b, cnt_b} !== 24'h0) begin
            bad++;
            $display("FAIL reset_state: got=%03h_%03h want=000_000",
                     {press_a, rel_a, rep_a, held_a, cnt_a}, {press_b, rel_b, rep_b, held_b, cnt_b});
        end
        reset_n = 1'b1;

        // Short press: press at edge 10, release at edge 13
        run_level(1'b0, 9);
        run_level(1'b1, 3);
        run_level(1'b0, 4);

        // Long hold with repeats, then release landing between repeats
        run_level(1'b1, 12);
        run_level(1'b0, 3);
        run_level(1'b1, 7);
        run_level(1'b0, 3);

        // Release on the edge the first repeat was due
        run_level(1'b1, 4);
        run_level(1'b0, 3);

        // Reset in the middle of a hold with the button still down
        run_level(1'b1, 5);
        do_reset(1'b1);
        run_level(1'b1, 3);
        run_level(1'b0, 2);

        // Counter wrap over 256 presses
        do_reset(1'b0);
        snap_p = mon_press;
        snap_r = mon_rel;
        for (int k = 0; k < 256; k++) begin
            run_level(1'b1, 2);
            run_level(1'b0, 2);
        end
        total++;
        if (cnt_a !== 8'd0) begin
            bad++;
            $display("FAIL wrap_count: got=%0d want=0", cnt_a);
        end
        total++;
        if (mon_press - snap_p != 256) begin
            bad++;
            $display("FAIL wrap_press_pulses: got=%0d want=256", mon_press - snap_p);
        end
        total++;
        if (mon_rel - snap_r != 256) begin
            bad++;
            $display("FAIL wrap_release_pulses: got=%0d want=256", mon_rel - snap_r);
        end

        // Random runs with occasional resets
        lvl = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                lvl = ~lvl;
                run_level(lvl, $urandom_range(1, 12));
            end
        end
        run_level(1'b0, 3);

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: got=%0d want=0", exp_q.size());
        end
        total++;
        if (mon_press != model_press) begin
            bad++;
            $display("FAIL press_total: got=%0d want=%0d", mon_press, model_press);
        end
        total++;
        if (mon_rel != model_rel) begin
            bad++;
            $display("FAIL release_total: got=%0d want=%0d", mon_rel, model_rel);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning cycles a press must last before the first repeat; legal range >= 2.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning cycles between successive repeats; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_debounc, input, 1 bit: debounced button level already synchronous to clk (1 = pressed).
REQ-006 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on press.
REQ-007 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on release.
REQ-008 The block SHALL have port repeat_pulse, output, 1 bit: one-cycle strobe per auto-repeat while held.
REQ-009 The block SHALL have port held, output, 1 bit: level, 1 while a press is active.
REQ-010 The block SHALL have port press_count, output, 8 bits: number of press events, modulo 256.

Function
REQ-011 All outputs SHALL be registered; no combinational path from btn_debounc to any output.
REQ-012 btn_debounc SHALL be sampled into register btn_q every edge; a press is edge E where btn_debounc=1 and btn_q=0; a release is btn_debounc=0 and btn_q=1.
REQ-013 FSM states SHALL be IDLE, PRESSED, REPEAT.
- IDLE -> PRESSED on press.
- PRESSED -> REPEAT when the hold timer expires.
- PRESSED/REPEAT -> IDLE on release.
REQ-014 On press at edge P: press_pulse=1 and held=1 after P; timer cleared to 0; press_count increments by 1, wrapping 255 -> 0.
REQ-015 The first repeat_pulse SHALL be asserted after edge P+HOLD_CYCLES; further repeat_pulses SHALL follow after edges P+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1.
REQ-016 With REPEAT_CYCLES=1, repeat_pulse SHALL stay high every cycle after the first repeat until release.
REQ-017 On release at edge R: release_pulse=1 and held=0 after R; timer cleared; state IDLE.
REQ-018 Release on an edge where a repeat was due SHALL suppress that repeat_pulse; release wins.
REQ-019 Each strobe SHALL be high for exactly one cycle per event, except as stated in REQ-016.
REQ-020 press_pulse and release_pulse SHALL never be high in the same cycle.
REQ-021 The timer SHALL be sized ceil(log2(max(HOLD_CYCLES,REPEAT_CYCLES)))+1 bits and SHALL never wrap; it is cleared on every state change and every repeat.

Reset
REQ-022 While reset=0, the block SHALL clear immediately, independent of clk: state IDLE, btn_q=0, timer=0, all strobes 0, held=0, press_count=0.
REQ-023 If btn_debounc=1 at reset deassertion, the first edge SHALL register a press (press_pulse=1, press_count=1).
REQ-024 Reset asserted mid-press or mid-repeat SHALL abort the press without a release_pulse.

Structure
REQ-025 Package button_event_pkg SHALL hold the state enum (IDLE, PRESSED, REPEAT), the default HOLD/REPEAT constants, and the press_count width constant (8).
REQ-026 One sub-module, cycle_timer, SHALL be used: a loadable or clearable up-counter with a terminal-count compare, instantiated once.

Verification (HOLD_CYCLES=4, REPEAT_CYCLES=2)
REQ-027 Press at edge 10, release at edge 13 -> press_pulse after 10; release_pulse after 13; no repeat_pulse; held high 10..13; press_count=1.
REQ-028 Press at edge 10, hold -> repeat_pulse after edges 14, 16, 18, 20; each strobe one cycle wide.
REQ-029 Press at edge 10, release at edge 17 -> repeats after 14 and 16 only; release_pulse after 17; nothing after 18.
REQ-030 Pulse reset low at edge 15 during hold, with btn_debounc still 1 -> all outputs 0 immediately; press_pulse on the first edge after release of reset; press_count=1.
REQ-031 256 press/release pairs (2 cycles pressed, 2 released) -> press_count reads 255 then 0; 256 press_pulses; 256 release_pulses.
REQ-032 Release on edge 14, coinciding with the first repeat -> release_pulse only; repeat_pulse stays 0.
